// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SPI_CNT_W  = 3;

    localparam logic [SPI_BYTE_W-1:0] IDLE_BYTE_DEFAULT = 8'h00;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_if_if.sv
// Pad-side SPI signals plus the byte-level RX/TX strobes of the slave front end.
interface spi_slave_if_if;
    import spi_pkg::*;

    logic                  spi_sck;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;

    // rx_dv and tx_dv are single-cycle valid strobes with no ready: the receiving
    // side must take rx_byte/tx_byte in the very cycle its strobe is high.
    logic                  rx_dv;
    logic [SPI_BYTE_W-1:0] rx_byte;
    logic                  tx_dv;
    logic [SPI_BYTE_W-1:0] tx_byte;

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi, tx_dv, tx_byte,
        output spi_miso, spi_miso_oe, rx_dv, rx_byte
    );

    modport master (
        output spi_sck, spi_cs_n, spi_mosi, tx_dv, tx_byte,
        input  spi_miso, spi_miso_oe, rx_dv, rx_byte
    );

endinterface

// File: rtl/spi_sync_bit.sv
// Multi-flop synchroniser for one asynchronous input, resetting to a chosen idle level.
module spi_sync_bit #(
    parameter logic RST_VAL = 1'b0,
    parameter int   STAGES  = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave (CPHA=0, selectable CPOL): oversampled pins, byte deserialiser, response serialiser.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter logic                  CPOL        = 1'b0,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    spi_slave_if_if.slave  bus,
    output logic           o_cs_active,
    output logic           o_frame_abort,
    output logic           o_tx_overrun,
    output spi_state_e     o_state
);

    localparam int FLUSH = SYNC_STAGES + 1;
    localparam int FW    = $clog2(FLUSH + 1);

    logic sck_s, cs_n_s, mosi_s;
    logic sck_q, cs_n_q;
    logic [FW-1:0] flush_cnt;
    logic armed, sck_edge, sck_lead, sck_trail, cs_fall, cs_rise;

    spi_state_e state_q, state_d;
    logic miso_oe, do_start, do_stop, do_sample, do_shift, do_load;

    logic [SPI_CNT_W-1:0]  bit_cnt;
    logic [6:0]            rx_shift;
    logic [SPI_BYTE_W-1:0] rx_next;
    logic [SPI_BYTE_W-1:0] rx_byte_q;
    logic                  rx_dv_q;
    logic [SPI_BYTE_W-1:0] tx_shift;
    logic [SPI_BYTE_W-1:0] hold;
    logic                  hold_valid;
    logic                  abort_q, ovr_q;

    spi_sync_bit #(.RST_VAL(CPOL), .STAGES(SYNC_STAGES)) u_sync_sck (
        .i_clk(i_clk), .i_rstn(i_rstn), .d(bus.spi_sck), .q(sck_s)
    );
    spi_sync_bit #(.RST_VAL(1'b1), .STAGES(SYNC_STAGES)) u_sync_cs (
        .i_clk(i_clk), .i_rstn(i_rstn), .d(bus.spi_cs_n), .q(cs_n_s)
    );
    spi_sync_bit #(.RST_VAL(1'b0), .STAGES(SYNC_STAGES)) u_sync_mosi (
        .i_clk(i_clk), .i_rstn(i_rstn), .d(bus.spi_mosi), .q(mosi_s)
    );

    // Edges are masked until the synchroniser has flushed its reset value, so a CS
    // held low across reset is not mistaken for a fresh falling edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sck_q     <= CPOL;
            cs_n_q    <= 1'b1;
            flush_cnt <= '0;
        end else begin
            sck_q  <= sck_s;
            cs_n_q <= cs_n_s;
            if (flush_cnt != FW'(FLUSH)) begin
                flush_cnt <= flush_cnt + FW'(1);
            end
        end
    end

    assign armed     = (flush_cnt == FW'(FLUSH));
    assign sck_edge  = armed & (sck_s ^ sck_q);
    assign sck_lead  = sck_edge & (sck_s != CPOL);
    assign sck_trail = sck_edge & (sck_s == CPOL);
    assign cs_fall   = armed & cs_n_q & ~cs_n_s;
    assign cs_rise   = armed & ~cs_n_q & cs_n_s;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= SPI_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SPI_IDLE:   if (cs_fall) state_d = SPI_ACTIVE;
            SPI_ACTIVE: if (cs_rise) state_d = SPI_IDLE;
            default:    state_d = SPI_IDLE;
        endcase
    end

    // A CS rise outranks any SCK edge detected in the same cycle.
    always_comb begin
        miso_oe   = 1'b0;
        do_start  = 1'b0;
        do_stop   = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        case (state_q)
            SPI_IDLE: begin
                do_start = cs_fall;
            end
            SPI_ACTIVE: begin
                miso_oe   = 1'b1;
                do_stop   = cs_rise;
                do_sample = ~cs_rise & sck_lead;
                do_shift  = ~cs_rise & sck_trail;
            end
            default: ;
        endcase
    end

    assign do_load = do_start | (do_shift & (bit_cnt == '0));
    assign rx_next = {rx_shift, mosi_s};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            rx_byte_q <= '0;
            rx_dv_q   <= 1'b0;
            tx_shift  <= '0;
            abort_q   <= 1'b0;
        end else begin
            rx_dv_q <= 1'b0;
            abort_q <= 1'b0;
            if (state_q == SPI_IDLE) begin
                bit_cnt <= '0;
            end
            if (do_stop) begin
                bit_cnt  <= '0;
                tx_shift <= '0;
                abort_q  <= (bit_cnt != '0);
            end
            if (do_sample) begin
                rx_shift <= rx_next[6:0];
                bit_cnt  <= bit_cnt + SPI_CNT_W'(1);
                if (bit_cnt == SPI_CNT_W'(7)) begin
                    rx_byte_q <= rx_next;
                    rx_dv_q   <= 1'b1;
                end
            end
            if (do_load) begin
                tx_shift <= hold_valid ? hold : IDLE_BYTE;
            end else if (do_shift) begin
                tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
            end
        end
    end

    // A strobe coinciding with a boundary load is kept for the following byte.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ovr_q <= bus.tx_dv & hold_valid & ~do_load;
            if (bus.tx_dv) begin
                hold       <= bus.tx_byte;
                hold_valid <= 1'b1;
            end else if (do_load | do_stop) begin
                hold_valid <= 1'b0;
            end
        end
    end

    assign bus.spi_miso    = tx_shift[SPI_BYTE_W-1];
    assign bus.spi_miso_oe = miso_oe;
    assign bus.rx_dv       = rx_dv_q;
    assign bus.rx_byte     = rx_byte_q;
    assign o_cs_active     = ~cs_n_s;
    assign o_frame_abort   = abort_q;
    assign o_tx_overrun    = ovr_q;
    assign o_state         = state_q;

endmodule
